mips_boot_ctrl: RTL and testbench
=================================

Name: mips_boot_ctrl

Overview:
Sequencer and memory-port arbiter between the MIPS core and its single-port 128-word Memory. After reset it holds the CPU in reset and gives the Memory port to a word-stream loader that writes a program image. It then releases the CPU and supports run, halt and single-step. It sits inside Complete_MIPS, between CPU, Memory and the external load/debug interface.

Parameters:
ADDR_W, 7, memory word-address width
DATA_W, 32, data word width
DEPTH, 128, memory words (2**ADDR_W)
CNT_W, 16, width of the run-cycle counter

Ports:
CLK  in  1  clock; Memory samples on negedge, this block on posedge
RST  in  1  reset, synchronous, active-high
ld_valid  in  1  loader word valid
ld_data  in  DATA_W  loader word
ld_last  in  1  final word of image, qualified by ld_valid
ld_ready  out  1  block accepts ld_data this cycle
start  in  1  level; release CPU from IDLE/DONE
halt_req  in  1  rising edge requests halt
step_req  in  1  rising edge in HALT runs exactly one CPU clock
reload_req  in  1  level; in HALT returns to IDLE for a new image
cpu_rst  out  1  drives MIPS RST
cpu_en  out  1  CPU state-update enable (MIPS gains this port)
cpu_cs, cpu_we  in  1  CPU memory strobes
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  DATA_W  CPU write data (CPU's Mem_Bus drive value)
mem_cs, mem_we  out  1  to Memory
mem_addr  out  ADDR_W  to Memory
mem_wdata  out  DATA_W  value placed on Mem_Bus when mem_wdata_oe=1
mem_wdata_oe  out  1  tri-state enable onto Mem_Bus
words_loaded  out  ADDR_W+1  words written by last load, 0..DEPTH
run_cycles  out  CNT_W  posedges with cpu_en=1, saturating
state_o  out  3  current state encoding

Behaviour:
- States: IDLE=0, WR=1, DONE=2, RUN=3, HALT=4, STEP=5. Next-state and outputs are combinational; registers update on posedge.
- RST=1 at posedge: state=IDLE, wptr=0, words_loaded=0, run_cycles=0, edge-detect registers=0. RST has priority over all other inputs and aborts any state, including a WR in progress, which is not re-issued.
- Outputs in IDLE/WR/DONE: cpu_rst=1, cpu_en=0; the block owns the Memory port.
- Output in RUN/HALT/STEP: cpu_rst=0; the CPU owns the Memory port.
- IDLE: ld_ready=1. ld_valid=1 at posedge: latch ld_data and ld_last, go WR. If ld_valid=0 and start=1, go RUN. ld_valid wins over start.
- WR: ld_ready=0, mem_cs=1, mem_we=1, mem_addr=wptr, mem_wdata=latched word, mem_wdata_oe=1. The write is held for a full cycle so the Memory negedge commits it. At posedge: wptr+1, words_loaded=wptr+1. Go DONE if last was latched or wptr==DEPTH-1; otherwise go IDLE. Sustained throughput is 1 word per 2 cycles.
- DONE: ld_ready=0 (excess words are not accepted). start=1 -> RUN.
- Any entry to IDLE from DONE or HALT clears wptr. Entry from WR keeps wptr.
- RUN: cpu_en=1. Memory outputs pass through from cpu_*. mem_wdata_oe=cpu_cs&cpu_we. A rising edge on halt_req -> HALT; that cycle still has cpu_en=1.
- HALT: cpu_en=0, mem_cs=0, mem_we=0, mem_wdata_oe=0. mem_addr=cpu_addr, so Memory data_out stays valid for a frozen fetch or load. Input priority: reload_req=1 -> IDLE with cpu_rst reasserted; else a step_req rising edge -> STEP; else start=1 -> RUN.
- STEP: exactly one cycle with pass-through and cpu_en=1, then HALT.
- Edge detect: a rising edge is input=1 while the registered previous value=0. A held level produces one event only.
- run_cycles increments at each posedge with cpu_en=1 and holds at all-ones. It clears only on RST or on entry to IDLE from HALT.
- Simultaneous halt_req edge and RUN entry are not possible: edges are only examined in RUN and HALT.

Decomposition:
- Package mips_sys_pkg holds:
  - state encodings ST_IDLE..ST_STEP
  - ADDR_W/DATA_W/DEPTH defaults, shared with Memory and MIPS
- One sub-module, rise_detect: 1-bit registered rising-edge detector with synchronous reset, instantiated for halt_req and step_req.
- Port muxing and the FSM stay in mips_boot_ctrl.

Test Plan:
- Load 3 words 0x20010005, 0x20020003, 0x00221820 (last on the third), then start -> Memory[0..2] holds the words; words_loaded=3; state DONE then RUN; cpu_rst falls the cycle after start; CPU ends with r3=8.
- ld_valid held high with ld_last never set -> exactly 128 writes at addresses 0..127; words_loaded=128; state DONE; ld_ready=0 thereafter.
- RUN 10 cycles, pulse halt_req -> state HALT after 1 cycle; run_cycles=11; mem_cs=0 while halted; CPU pc unchanged for 20 cycles.
- In HALT, hold step_req high for 5 cycles -> run_cycles increments by exactly 1; state sequence HALT,STEP,HALT.
- In HALT, assert reload_req, then load 1 word 0x08000000 with last -> cpu_rst=1 during the load; words_loaded=1; run_cycles=0; Memory[0]=0x08000000.
- Assert RST during WR -> next state IDLE; words_loaded=0; the interrupted address is not rewritten afterwards.

Source files
------------

// File: rtl/mips_sys_pkg.sv
// Shared Complete_MIPS definitions: memory geometry and boot-controller state encodings.
package mips_sys_pkg;

  localparam int unsigned ADDR_W = 7;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 2 ** ADDR_W;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WR   = 3'd1,
    ST_DONE = 3'd2,
    ST_RUN  = 3'd3,
    ST_HALT = 3'd4,
    ST_STEP = 3'd5
  } state_t;

endpackage

// File: rtl/rise_detect.sv
// One-bit rising-edge detector: a held level yields a single-cycle event.
module rise_detect (
  input  logic CLK,
  input  logic RST,
  input  logic din,
  output logic rise_c
);

  logic prev;

  always_ff @(posedge CLK) begin
    if (RST) prev <= 1'b0;
    else     prev <= din;
  end

  assign rise_c = din & ~prev;

endmodule

// File: rtl/mips_boot_ctrl.sv
// Boot sequencer and Memory-port arbiter: loads a program image, then runs/halts/steps the CPU.
module mips_boot_ctrl
  import mips_sys_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  input  logic              start,
  input  logic              halt_req,
  input  logic              step_req,
  input  logic              reload_req,
  output logic              cpu_rst,
  output logic              cpu_en,
  input  logic              cpu_cs,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              mem_cs,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wdata_oe,
  output logic [ADDR_W:0]   words_loaded,
  output logic [CNT_W-1:0]  run_cycles,
  output logic [2:0]        state_o
);

  localparam int unsigned WL_W = ADDR_W + 1;

  state_t              state, state_d;
  logic [ADDR_W-1:0]   wptr;
  logic [DATA_W-1:0]   ld_word;
  logic                ld_last_q;
  logic                halt_rise_c, step_rise_c;

  rise_detect u_halt_rise (.CLK(CLK), .RST(RST), .din(halt_req), .rise_c(halt_rise_c));
  rise_detect u_step_rise (.CLK(CLK), .RST(RST), .din(step_req), .rise_c(step_rise_c));

  // Next state and port muxing; the loader owns Memory until the CPU is released.
  always_comb begin
    state_d      = state;
    ld_ready     = 1'b0;
    cpu_rst      = 1'b1;
    cpu_en       = 1'b0;
    mem_cs       = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = wptr;
    mem_wdata    = ld_word;
    mem_wdata_oe = 1'b0;
    case (state)
      ST_IDLE: begin
        ld_ready = 1'b1;
        if (ld_valid)   state_d = ST_WR;
        else if (start) state_d = ST_RUN;
      end
      ST_WR: begin
        mem_cs       = 1'b1;
        mem_we       = 1'b1;
        mem_wdata_oe = 1'b1;
        if (ld_last_q || wptr == ADDR_W'(DEPTH - 1)) state_d = ST_DONE;
        else                                         state_d = ST_IDLE;
      end
      ST_DONE: begin
        if (start) state_d = ST_RUN;
      end
      ST_RUN, ST_STEP: begin
        cpu_rst      = 1'b0;
        cpu_en       = 1'b1;
        mem_cs       = cpu_cs;
        mem_we       = cpu_we;
        mem_addr     = cpu_addr;
        mem_wdata    = cpu_wdata;
        mem_wdata_oe = cpu_cs & cpu_we;
        if (state == ST_STEP)  state_d = ST_HALT;
        else if (halt_rise_c)  state_d = ST_HALT;
      end
      ST_HALT: begin
        // Address stays on the CPU so a frozen fetch/load keeps valid read data.
        cpu_rst   = 1'b0;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        if (reload_req)       state_d = ST_IDLE;
        else if (step_rise_c) state_d = ST_STEP;
        else if (start)       state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= ST_IDLE;
      wptr         <= '0;
      ld_word      <= '0;
      ld_last_q    <= 1'b0;
      words_loaded <= '0;
      run_cycles   <= '0;
    end else begin
      state <= state_d;
      if (state == ST_IDLE && ld_valid) begin
        ld_word   <= ld_data;
        ld_last_q <= ld_last;
      end
      if (state == ST_WR) begin
        wptr         <= wptr + ADDR_W'(1);
        words_loaded <= WL_W'(wptr) + WL_W'(1);
      end
      // A reload starts a fresh image and a fresh cycle count.
      if (state == ST_HALT && state_d == ST_IDLE) begin
        wptr       <= '0;
        run_cycles <= '0;
      end else if (cpu_en && run_cycles != {CNT_W{1'b1}}) begin
        run_cycles <= run_cycles + CNT_W'(1);
      end
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_mips_boot_ctrl.sv
// Directed self-checking bench for mips_boot_ctrl with a negedge Memory model.
module tb_mips_boot_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ld_valid, ld_last, ld_ready;
  logic [31:0] ld_data;
  logic        start, halt_req, step_req, reload_req;
  logic        cpu_rst, cpu_en, cpu_cs, cpu_we;
  logic [6:0]  cpu_addr;
  logic [31:0] cpu_wdata;
  logic        mem_cs, mem_we, mem_wdata_oe;
  logic [6:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [7:0]  words_loaded;
  logic [15:0] run_cycles;
  logic [2:0]  state_o;

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] mem_m [128];
  int          wcount [128];

  always #5 CLK = ~CLK;

  mips_boot_ctrl dut (
    .CLK(CLK), .RST(RST),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
    .start(start), .halt_req(halt_req), .step_req(step_req), .reload_req(reload_req),
    .cpu_rst(cpu_rst), .cpu_en(cpu_en),
    .cpu_cs(cpu_cs), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wdata_oe(mem_wdata_oe), .words_loaded(words_loaded), .run_cycles(run_cycles),
    .state_o(state_o)
  );

  // Memory commits on the falling edge, like the real single-port RAM.
  always @(negedge CLK) begin
    if (mem_cs && mem_we) begin
      mem_m[mem_addr]  = mem_wdata;
      wcount[mem_addr] = wcount[mem_addr] + 1;
    end
  end

  typedef struct {
    logic        ldv;  logic [31:0] ldd;  logic ldl;
    logic        st;   logic hr;  logic sr;  logic rr;
    logic        cs;   logic we;  logic [6:0] ca;  logic [31:0] cw;
    logic [2:0]  e_st; logic e_rdy; logic e_crst; logic e_cen;
    logic        e_mcs; logic e_mwe; logic [6:0] e_ma; logic [31:0] e_mwd;
    logic        e_oe; logic [7:0] e_wl; logic [15:0] e_rc;
  } vec_t;

  localparam logic [31:0] WA = 32'h20010005;
  localparam logic [31:0] WB = 32'h20020003;
  localparam logic [31:0] WC = 32'h00221820;
  localparam logic [31:0] WX = 32'hDEADBEEF;
  localparam logic [31:0] WD = 32'h08000000;

  vec_t vecs [21];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    ld_valid = 0; ld_data = '0; ld_last = 0; start = 0; halt_req = 0;
    step_req = 0; reload_req = 0; cpu_cs = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    RST = 1;
    cyc();
    cyc();
    RST = 0;
    for (int i = 0; i < 128; i++) begin
      wcount[i] = 0;
      mem_m[i]  = '0;
    end
  endtask

  initial begin
    int n_acc, bad, tot, rc0;
    logic acc;
    logic [2:0] exp_seq [5];

    // {ldv ldd ldl st hr sr rr cs we ca cw | st rdy crst cen mcs mwe ma mwd oe wl rc}
    vecs[0]  = '{1, WA, 0, 0,0,0,0, 0,0, 7'd0, 0,   3'd0, 1,1,0, 0,0, 7'd0, 0,  0, 8'd0, 16'd0};
    vecs[1]  = '{1, WB, 0, 0,0,0,0, 0,0, 7'd0, 0,   3'd1, 0,1,0, 1,1, 7'd0, WA, 1, 8'd0, 16'd0};
    vecs[2]  = '{1, WB, 0, 0,0,0,0, 0,0, 7'd0, 0,   3'd0, 1,1,0, 0,0, 7'd0, 0,  0, 8'd1, 16'd0};
    vecs[3]  = '{0, 0,  0, 0,0,0,0, 0,0, 7'd0, 0,   3'd1, 0,1,0, 1,1, 7'd1, WB, 1, 8'd1, 16'd0};
    vecs[4]  = '{1, WC, 1, 0,0,0,0, 0,0, 7'd0, 0,   3'd0, 1,1,0, 0,0, 7'd0, 0,  0, 8'd2, 16'd0};
    vecs[5]  = '{0, 0,  0, 0,0,0,0, 0,0, 7'd0, 0,   3'd1, 0,1,0, 1,1, 7'd2, WC, 1, 8'd2, 16'd0};
    vecs[6]  = '{1, 32'h11111111, 0, 0,0,0,0, 0,0, 7'd0, 0, 3'd2, 0,1,0, 0,0, 7'd0, 0, 0, 8'd3, 16'd0};
    vecs[7]  = '{0, 0,  0, 1,0,0,0, 0,0, 7'd0, 0,   3'd2, 0,1,0, 0,0, 7'd0, 0,  0, 8'd3, 16'd0};
    vecs[8]  = '{0, 0,  0, 0,0,0,0, 1,0, 7'd5, 0,   3'd3, 0,0,1, 1,0, 7'd5, 0,  0, 8'd3, 16'd0};
    vecs[9]  = '{0, 0,  0, 0,0,0,0, 1,1, 7'd9, WX,  3'd3, 0,0,1, 1,1, 7'd9, WX, 1, 8'd3, 16'd1};
    vecs[10] = '{0, 0,  0, 0,1,0,0, 0,0, 7'd0, 0,   3'd3, 0,0,1, 0,0, 7'd0, 0,  0, 8'd3, 16'd2};
    vecs[11] = '{0, 0,  0, 0,1,0,0, 1,1, 7'd7, WX,  3'd4, 0,0,0, 0,0, 7'd7, 0,  0, 8'd3, 16'd3};
    vecs[12] = '{0, 0,  0, 0,0,1,0, 0,0, 7'd7, 0,   3'd4, 0,0,0, 0,0, 7'd7, 0,  0, 8'd3, 16'd3};
    vecs[13] = '{0, 0,  0, 0,0,1,0, 1,0, 7'd3, 0,   3'd5, 0,0,1, 1,0, 7'd3, 0,  0, 8'd3, 16'd3};
    vecs[14] = '{0, 0,  0, 0,0,1,0, 0,0, 7'd3, 0,   3'd4, 0,0,0, 0,0, 7'd3, 0,  0, 8'd3, 16'd4};
    vecs[15] = '{0, 0,  0, 1,0,0,0, 0,0, 7'd0, 0,   3'd4, 0,0,0, 0,0, 7'd0, 0,  0, 8'd3, 16'd4};
    vecs[16] = '{0, 0,  0, 0,1,0,0, 0,0, 7'd0, 0,   3'd3, 0,0,1, 0,0, 7'd0, 0,  0, 8'd3, 16'd4};
    vecs[17] = '{0, 0,  0, 0,0,0,1, 0,0, 7'd0, 0,   3'd4, 0,0,0, 0,0, 7'd0, 0,  0, 8'd3, 16'd5};
    vecs[18] = '{1, WD, 1, 0,0,0,0, 0,0, 7'd0, 0,   3'd0, 1,1,0, 0,0, 7'd0, 0,  0, 8'd3, 16'd0};
    vecs[19] = '{0, 0,  0, 0,0,0,0, 0,0, 7'd0, 0,   3'd1, 0,1,0, 1,1, 7'd0, WD, 1, 8'd3, 16'd0};
    vecs[20] = '{0, 0,  0, 0,0,0,0, 0,0, 7'd0, 0,   3'd2, 0,1,0, 0,0, 7'd0, 0,  0, 8'd1, 16'd0};

    // Reset state
    do_reset();
    @(negedge CLK);
    chk("rst_state", 64'(state_o), 64'd0);
    chk("rst_wl", 64'(words_loaded), 64'd0);
    chk("rst_rc", 64'(run_cycles), 64'd0);
    chk("rst_cpu", {62'd0, cpu_rst, cpu_en}, 64'd2);
    chk("rst_ld_ready", 64'(ld_ready), 64'd1);
    cyc();

    // Load, run, halt, step, reload table
    for (int i = 0; i < 21; i++) begin
      ld_valid = vecs[i].ldv; ld_data = vecs[i].ldd; ld_last = vecs[i].ldl;
      start = vecs[i].st; halt_req = vecs[i].hr; step_req = vecs[i].sr; reload_req = vecs[i].rr;
      cpu_cs = vecs[i].cs; cpu_we = vecs[i].we; cpu_addr = vecs[i].ca; cpu_wdata = vecs[i].cw;
      @(negedge CLK);
      chk($sformatf("v%0d_state", i), 64'(state_o), 64'(vecs[i].e_st));
      chk($sformatf("v%0d_ctl", i), {58'd0, ld_ready, cpu_rst, cpu_en, mem_cs, mem_we, mem_wdata_oe},
          {58'd0, vecs[i].e_rdy, vecs[i].e_crst, vecs[i].e_cen, vecs[i].e_mcs, vecs[i].e_mwe, vecs[i].e_oe});
      chk($sformatf("v%0d_wl", i), 64'(words_loaded), 64'(vecs[i].e_wl));
      chk($sformatf("v%0d_rc", i), 64'(run_cycles), 64'(vecs[i].e_rc));
      if (vecs[i].e_mcs || vecs[i].e_st == 3'd4)
        chk($sformatf("v%0d_addr", i), 64'(mem_addr), 64'(vecs[i].e_ma));
      if (vecs[i].e_oe)
        chk($sformatf("v%0d_wdata", i), 64'(mem_wdata), 64'(vecs[i].e_mwd));
      cyc();
    end
    idle_inputs();
    chk("img_mem0", 64'(mem_m[0]), 64'(WD));
    chk("img_mem1", 64'(mem_m[1]), 64'(WB));
    chk("img_mem2", 64'(mem_m[2]), 64'(WC));
    chk("img_mem9", 64'(mem_m[9]), 64'(WX));

    // Full 128-word image with ld_valid held and no last
    do_reset();
    n_acc = 0;
    ld_valid = 1;
    for (int c = 0; c < 400; c++) begin
      ld_data = 32'hA5000000 | 32'(n_acc);
      @(negedge CLK);
      acc = ld_ready;
      if (state_o == 3'd2) break;
      cyc();
      if (acc) n_acc++;
    end
    chk("fill_state", 64'(state_o), 64'd2);
    chk("fill_accepted", 64'(n_acc), 64'd128);
    chk("fill_wl", 64'(words_loaded), 64'd128);
    bad = 0; tot = 0;
    for (int a = 0; a < 128; a++) begin
      tot += wcount[a];
      if (wcount[a] != 1 || mem_m[a] != (32'hA5000000 | 32'(a))) bad++;
    end
    chk("fill_bad_addrs", 64'(bad), 64'd0);
    chk("fill_writes", 64'(tot), 64'd128);
    for (int c = 0; c < 3; c++) begin
      cyc();
      @(negedge CLK);
      chk("fill_ready_low", {62'd0, ld_ready, mem_cs}, 64'd0);
    end
    cyc();
    idle_inputs();

    // Run 10 cycles, halt on the 11th, stay frozen, then single-step
    do_reset();
    start = 1;
    cyc();
    start = 0;
    repeat (10) cyc();
    halt_req = 1;
    @(negedge CLK);
    chk("run_before_halt", 64'(state_o), 64'd3);
    cyc();
    halt_req = 0;
    cpu_cs = 1; cpu_we = 1; cpu_addr = 7'd7;
    @(negedge CLK);
    chk("halt_state", 64'(state_o), 64'd4);
    chk("halt_rc", 64'(run_cycles), 64'd11);
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      if (mem_cs || mem_we || mem_wdata_oe || cpu_en || mem_addr != 7'd7 || state_o != 3'd4) bad++;
      cyc();
    end
    chk("halt_frozen", 64'(bad), 64'd0);
    chk("halt_rc_hold", 64'(run_cycles), 64'd11);
    exp_seq[0] = 3'd4; exp_seq[1] = 3'd5; exp_seq[2] = 3'd4; exp_seq[3] = 3'd4; exp_seq[4] = 3'd4;
    step_req = 1;
    rc0 = int'(run_cycles);
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      chk($sformatf("step_seq%0d", c), 64'(state_o), 64'(exp_seq[c]));
      cyc();
    end
    step_req = 0;
    chk("step_rc", 64'(run_cycles), 64'(rc0 + 1));
    idle_inputs();

    // RST during a write: aborted and never re-issued
    do_reset();
    ld_valid = 1; ld_data = 32'h11110000;
    cyc();
    ld_valid = 0;
    cyc();
    ld_valid = 1; ld_data = 32'h22220000;
    cyc();
    ld_valid = 0;
    @(negedge CLK);
    chk("abort_in_wr", {57'd0, state_o, mem_addr[3:0]}, {57'd0, 3'd1, 4'd1});
    RST = 1;
    cyc();
    RST = 0;
    @(negedge CLK);
    chk("abort_state", 64'(state_o), 64'd0);
    chk("abort_wl", 64'(words_loaded), 64'd0);
    repeat (4) cyc();
    chk("abort_no_rewrite", 64'(wcount[1]), 64'd1);
    ld_valid = 1; ld_data = 32'h33330000; ld_last = 1;
    cyc();
    ld_valid = 0; ld_last = 0;
    cyc();
    @(negedge CLK);
    chk("abort_reload_mem0", 64'(mem_m[0]), 64'h33330000);
    chk("abort_reload_wl", 64'(words_loaded), 64'd1);
    chk("abort_addr1_once", 64'(wcount[1]), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
